// File: rtl/acumulador_pkg.sv
// Shared constants for the result accumulator: FSM state encodings and the
// width of the word produced by the upstream 2-bit adder.
package acumulador_pkg;

  localparam int unsigned RESULTADO_W = 3;

  localparam logic [1:0] OCIOSO     = 2'd0;
  localparam logic [1:0] ACUMULANDO = 2'd1;
  localparam logic [1:0] PRONTO     = 2'd2;

endpackage

// File: rtl/acumulador_resultado_if.sv
// Handshake/result bundle between the adder-side producer, the total consumer
// and acumulador_resultado. The master modport is the producer/consumer side.
interface acumulador_resultado_if #(
  parameter int unsigned LARGURA = 6
);
  logic [acumulador_pkg::RESULTADO_W-1:0] resultado;
  logic                                   entrada_valida;
  logic                                   entrada_pronta;
  logic                                   leitura;
  logic [LARGURA-1:0]                     soma_total;
  logic                                   total_valido;
  logic [3:0]                             contagem;
  logic                                   estouro;

  modport master (
    output resultado, entrada_valida, leitura,
    input  entrada_pronta, soma_total, total_valido, contagem, estouro
  );

  modport slave (
    input  resultado, entrada_valida, leitura,
    output entrada_pronta, soma_total, total_valido, contagem, estouro
  );
endinterface

// File: rtl/acumulador_resultado.sv
// Accumulates N_AMOSTRAS adder results into one total with a sticky overflow flag.
// Define ACUMULADOR_SATURACAO_EN to clamp on overflow instead of wrapping.
module acumulador_resultado
  import acumulador_pkg::*;
#(
  parameter int unsigned LARGURA    = 6,
  parameter int unsigned N_AMOSTRAS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  acumulador_resultado_if.slave  bus_io
);

  localparam logic [3:0] ContagemFinal = 4'(N_AMOSTRAS);

  logic [1:0]         estado_q, estado_d;
  logic [LARGURA-1:0] soma_q, soma_d;
  logic [3:0]         contagem_q, contagem_d;
  logic               estouro_q, estouro_d;
  logic               transferencia;
  logic [LARGURA:0]   soma_ext;

  assign transferencia = bus_io.entrada_valida && (estado_q != PRONTO);
  // One extra bit exposes the carry out of the accumulator for overflow detection.
  assign soma_ext      = {1'b0, soma_q} + (LARGURA+1)'(bus_io.resultado);

  always_comb begin
    estado_d   = estado_q;
    soma_d     = soma_q;
    contagem_d = contagem_q;
    estouro_d  = estouro_q;
    case (estado_q)
      OCIOSO, ACUMULANDO: begin
        if (transferencia) begin
          contagem_d = contagem_q + 4'd1;
          estouro_d  = estouro_q | soma_ext[LARGURA];
`ifdef ACUMULADOR_SATURACAO_EN
          soma_d     = soma_ext[LARGURA] ? '1 : soma_ext[LARGURA-1:0];
`else
          soma_d     = soma_ext[LARGURA-1:0];
`endif
          estado_d   = (contagem_d == ContagemFinal) ? PRONTO : ACUMULANDO;
        end
      end
      PRONTO: begin
        if (bus_io.leitura) begin
          soma_d     = '0;
          contagem_d = '0;
          estouro_d  = 1'b0;
          estado_d   = OCIOSO;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      soma_q     <= '0;
      contagem_q <= '0;
      estouro_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      soma_q     <= soma_d;
      contagem_q <= contagem_d;
      estouro_q  <= estouro_d;
    end
  end

  assign bus_io.entrada_pronta = (estado_q != PRONTO);
  assign bus_io.total_valido   = (estado_q == PRONTO);
  assign bus_io.soma_total     = soma_q;
  assign bus_io.contagem       = contagem_q;
  assign bus_io.estouro        = estouro_q;

endmodule

// File: doc/acumulador_resultado.md
ACUMULADOR_RESULTADO -- requirements
Module: acumulador_resultado

Interface
REQ-001 SHALL have parameter LARGURA, default 6: accumulator width in bits; legal values 4..16.
REQ-002 SHALL have parameter N_AMOSTRAS, default 4: number of transfers per total; legal values 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port resultado, input, 3 bits: unsigned carry-out/sum word from the upstream 2-bit adder.
REQ-006 SHALL have port entrada_valida, input, 1 bit: resultado is valid this cycle.
REQ-007 SHALL have port entrada_pronta, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port leitura, input, 1 bit: consumer acknowledges the presented total.
REQ-009 SHALL have port soma_total, output, LARGURA bits: running or final accumulated sum.
REQ-010 SHALL have port total_valido, output, 1 bit: soma_total is final.
REQ-011 SHALL have port contagem, output, 4 bits: number of words accepted in the current batch.
REQ-012 SHALL have port estouro, output, 1 bit: sticky overflow flag for the current batch.

Function
REQ-013 SHALL define a transfer as a rising clk edge with entrada_valida=1 and entrada_pronta=1.
REQ-014 SHALL implement FSM states OCIOSO (contagem=0), ACUMULANDO (0<contagem<N_AMOSTRAS) and PRONTO (contagem=N_AMOSTRAS).
REQ-015 SHALL drive entrada_pronta=1 in OCIOSO and ACUMULANDO and 0 in PRONTO; entrada_pronta SHALL not depend combinationally on entrada_valida.
REQ-016 SHALL on each transfer set soma_total <= soma_total + zero-extended resultado and contagem <= contagem+1, visible the cycle after the edge.
REQ-017 SHALL enter PRONTO on the transfer that makes contagem equal N_AMOSTRAS; with N_AMOSTRAS=1 this is OCIOSO -> PRONTO directly.
REQ-018 SHALL drive total_valido=1 only in PRONTO, holding soma_total, contagem and estouro stable until leitura.
REQ-019 SHALL, on an edge in PRONTO with leitura=1, clear soma_total, contagem and estouro and return to OCIOSO; no word is accepted on that edge.
REQ-020 SHALL ignore leitura in OCIOSO and ACUMULANDO.
REQ-021 SHALL ignore resultado while entrada_valida=0 or entrada_pronta=0; entrada_valida held high in PRONTO causes no change.
REQ-022 SHALL set estouro=1 on any transfer whose true sum exceeds 2^LARGURA-1; estouro then stays 1 until leitura or rst.

Reset
REQ-023 SHALL on rst=1, immediately and independent of clk, force state OCIOSO, soma_total=0, contagem=0, estouro=0, total_valido=0, entrada_pronta=1 (driven once rst releases).
REQ-024 SHALL discard a partially accumulated batch when rst asserts mid-batch; no transfer occurs on an edge while rst=1.

Configuration
REQ-025 SHALL, with macro ACUMULADOR_SATURACAO_EN defined, clamp soma_total to 2^LARGURA-1 on overflow.
REQ-026 SHALL, with ACUMULADOR_SATURACAO_EN undefined, wrap soma_total modulo 2^LARGURA on overflow; estouro behaviour identical in both builds.

Structure
REQ-027 SHALL take FSM state encodings (OCIOSO=2'd0, ACUMULANDO=2'd1, PRONTO=2'd2) and the 3-bit resultado width constant from shared package acumulador_pkg.
REQ-028 SHALL be a single module; the upstream 2-bit adder is instantiated by the integrating top level, not inside this block.

Verification
REQ-029 SHALL cover: defaults, transfers of 3,5,7,1 on consecutive cycles -> total_valido=1 one cycle after 4th transfer, soma_total=16, estouro=0, entrada_pronta=0.
REQ-030 SHALL cover: LARGURA=4, N_AMOSTRAS=3, transfers 7,7,7 -> soma_total=5, estouro=1 (wrap build); soma_total=15, estouro=1 (ACUMULADOR_SATURACAO_EN build).
REQ-031 SHALL cover: in PRONTO hold entrada_valida=1, resultado=6 for 5 cycles, then leitura=1 -> total unchanged during hold; next cycle soma_total=0, contagem=0, OCIOSO.
REQ-032 SHALL cover: after 2 transfers (2,3), assert rst between clock edges -> outputs zero at once; after release, transfer 4 -> soma_total=4, contagem=1.
REQ-033 SHALL cover: leitura=1 pulsed in OCIOSO and ACUMULANDO with gaps in entrada_valida -> no clearing; gaps add nothing; final total matches sum of accepted words only.
